// File: rtl/aes_enc_sequencer_if.sv
// Handshake bundle between the AES sequencer, its producer/consumer and the round controller.
// slave = sequencer side, master = environment (producer, consumer, core) side.
interface aes_enc_sequencer_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pt_s0;
  logic [DATA_W-1:0] in_pt_s1;
  logic [DATA_W-1:0] in_key_s0;
  logic [DATA_W-1:0] in_key_s1;
  logic              core_start;
  logic [DATA_W-1:0] core_pt_s0;
  logic [DATA_W-1:0] core_pt_s1;
  logic [DATA_W-1:0] core_key_s0;
  logic [DATA_W-1:0] core_key_s1;
  logic              core_done;
  logic [DATA_W-1:0] core_ct_s0;
  logic [DATA_W-1:0] core_ct_s1;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ct_s0;
  logic [DATA_W-1:0] out_ct_s1;
  logic              busy;
  logic              err;

  modport slave (
    input  in_valid, in_pt_s0, in_pt_s1, in_key_s0, in_key_s1,
    output in_ready,
    output core_start, core_pt_s0, core_pt_s1, core_key_s0, core_key_s1,
    input  core_done, core_ct_s0, core_ct_s1,
    output out_valid, out_ct_s0, out_ct_s1,
    input  out_ready,
    output busy, err
  );

  modport master (
    output in_valid, in_pt_s0, in_pt_s1, in_key_s0, in_key_s1,
    input  in_ready,
    input  core_start, core_pt_s0, core_pt_s1, core_key_s0, core_key_s1,
    output core_done, core_ct_s0, core_ct_s1,
    input  out_valid, out_ct_s0, out_ct_s1,
    output out_ready,
    input  busy, err
  );
endinterface

// File: rtl/aes_enc_sequencer.sv
// Valid/ready front/back end for the masked AES core: loads 2-share pt/key, pulses start, captures 2-share ct.
// Optional RUN-state watchdog compiled in with `define AES_SEQ_WATCHDOG_EN.
module aes_enc_sequencer #(
  parameter int DATA_W          = 128,
  parameter int WATCHDOG_CYCLES = 64
) (
  input logic                 clk,
  input logic                 rst,
  aes_enc_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  if (WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > 255) begin : g_bad_wd
    $error("WATCHDOG_CYCLES must be within 1..255");
  end

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_pt_s0, r_pt_s1, r_key_s0, r_key_s1;
  logic [DATA_W-1:0] r_ct_s0, r_ct_s1;
  logic              w_accept;
  logic              w_capture;
  logic              w_release;
  logic              w_abort;

  assign w_accept  = (r_state == S_IDLE) & bus.in_valid;
  // core_done only counts in RUN; a done still high from the previous operation is ignored elsewhere
  assign w_capture = (r_state == S_RUN) & bus.core_done;
  assign w_release = (r_state == S_OUT) & bus.out_ready;

`ifdef AES_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(WATCHDOG_CYCLES);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_inc;
  logic       r_err;

  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_abort   = (r_state == S_RUN) & ~bus.core_done & (w_cnt_inc >= WD_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (w_accept)
        r_cnt <= 8'd0;
      else if (r_state == S_RUN)
        r_cnt <= w_cnt_inc;
      if (w_accept)
        r_err <= 1'b0;
      else if (w_abort)
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_abort = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_RUN;
      S_RUN:   if (w_capture) w_state_nxt = S_OUT;
               else if (w_abort) w_state_nxt = S_IDLE;
      S_OUT:   if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Shares travel in separate registers and are never recombined here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pt_s0  <= '0;
      r_pt_s1  <= '0;
      r_key_s0 <= '0;
      r_key_s1 <= '0;
    end else if (w_accept) begin
      r_pt_s0  <= bus.in_pt_s0;
      r_pt_s1  <= bus.in_pt_s1;
      r_key_s0 <= bus.in_key_s0;
      r_key_s1 <= bus.in_key_s1;
    end else if (w_abort) begin
      r_pt_s0  <= '0;
      r_pt_s1  <= '0;
      r_key_s0 <= '0;
      r_key_s1 <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ct_s0 <= '0;
      r_ct_s1 <= '0;
    end else if (w_capture) begin
      r_ct_s0 <= bus.core_ct_s0;
      r_ct_s1 <= bus.core_ct_s1;
    end else if (w_abort) begin
      r_ct_s0 <= '0;
      r_ct_s1 <= '0;
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.core_start  = (r_state == S_LOAD);
  assign bus.out_valid   = (r_state == S_OUT);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.core_pt_s0  = r_pt_s0;
  assign bus.core_pt_s1  = r_pt_s1;
  assign bus.core_key_s0 = r_key_s0;
  assign bus.core_key_s1 = r_key_s1;
  assign bus.out_ct_s0   = r_ct_s0;
  assign bus.out_ct_s1   = r_ct_s1;

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Directed bench for aes_enc_sequencer: the initial block plays producer, consumer and round-controller stub.
module tb_aes_enc_sequencer;

  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MSK0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT1  = 128'hdeadbeefcafef00d1122334455667788;
  localparam logic [127:0] PT1M = 128'h5a5a5a5a0f0f0f0f3c3c3c3cc3c3c3c3;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] MSK1 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] JUNK = 128'hffff0000ffff0000ffff0000ffff0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  logic seen_valid;
  logic stable_ok;

  always #5 clk = ~clk;

  aes_enc_sequencer_if #(.DATA_W(128)) bus ();

  aes_enc_sequencer #(.DATA_W(128), .WATCHDOG_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic [127:0] p0, input logic [127:0] p1,
                          input logic [127:0] k0, input logic [127:0] k1);
    bus.in_valid  = 1'b1;
    bus.in_pt_s0  = p0;
    bus.in_pt_s1  = p1;
    bus.in_key_s0 = k0;
    bus.in_key_s1 = k1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_pt_s0   = '0;
    bus.in_pt_s1   = '0;
    bus.in_key_s0  = '0;
    bus.in_key_s1  = '0;
    bus.core_done  = 1'b0;
    bus.core_ct_s0 = '0;
    bus.core_ct_s1 = '0;
    bus.out_ready  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_err", 128'(bus.err), 128'd0);
    chk("rst_core_start", 128'(bus.core_start), 128'd0);
    chk("rst_core_pt", bus.core_pt_s0, 128'd0);
    chk("rst_out_ct", bus.out_ct_s0, 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 128'(bus.in_ready), 128'd1);

    // basic operation, done 45 cycles after core_start
    drive_in(PT0, 128'd0, KEY0, 128'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("basic_start", 128'(bus.core_start), 128'd1);
    chk("basic_in_ready", 128'(bus.in_ready), 128'd0);
    chk("basic_core_pt", bus.core_pt_s0, PT0);
    chk("basic_core_key", bus.core_key_s0, KEY0);
    tick();
    chk("basic_start_once", 128'(bus.core_start), 128'd0);
    chk("basic_busy", 128'(bus.busy), 128'd1);
    for (int i = 0; i < 44; i++) tick();
    bus.core_done  = 1'b1;
    bus.core_ct_s0 = CT0 ^ MSK0;
    bus.core_ct_s1 = MSK0;
    chk("basic_no_early_valid", 128'(bus.out_valid), 128'd0);
    tick();
    chk("basic_out_valid", 128'(bus.out_valid), 128'd1);
    chk("basic_ct_xor", bus.out_ct_s0 ^ bus.out_ct_s1, CT0);
    chk("basic_ct_s0", bus.out_ct_s0, CT0 ^ MSK0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("basic_done_valid", 128'(bus.out_valid), 128'd0);
    chk("basic_back_idle", 128'(bus.in_ready), 128'd1);

    // stale done still high from previous op; then backpressure
    drive_in(PT1, PT1M, KEY0, MSK1);
    tick();
    bus.in_valid = 1'b0;
    chk("stale_start", 128'(bus.core_start), 128'd1);
    chk("stale_load_no_valid", 128'(bus.out_valid), 128'd0);
    chk("stale_core_pt_s1", bus.core_pt_s1, PT1M);
    tick();
    bus.core_done = 1'b0;
    chk("stale_run_no_valid", 128'(bus.out_valid), 128'd0);
    for (int i = 0; i < 5; i++) tick();
    drive_in(JUNK, JUNK, JUNK, JUNK);
    tick();
    bus.in_valid = 1'b0;
    chk("ignore_in_run", bus.core_pt_s0, PT1);
    chk("stale_still_busy", 128'(bus.out_valid), 128'd0);
    bus.core_done  = 1'b1;
    bus.core_ct_s0 = CT1 ^ MSK1;
    bus.core_ct_s1 = MSK1;
    tick();
    chk("bp_valid", 128'(bus.out_valid), 128'd1);
    chk("bp_ct_xor", bus.out_ct_s0 ^ bus.out_ct_s1, CT1);
    bus.core_ct_s0 = JUNK;
    bus.core_ct_s1 = ~JUNK;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_pt_s0 = JUNK;
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_ct_s0 !== (CT1 ^ MSK1) || bus.out_ct_s1 !== MSK1 ||
          bus.core_pt_s0 !== PT1)
        stable_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bp_stable_10", 128'(stable_ok), 128'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 128'(bus.out_valid), 128'd0);
    chk("bp_release_ready", 128'(bus.in_ready), 128'd1);
    drive_in(PT0, MSK0, KEY0, MSK1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_start", 128'(bus.core_start), 128'd1);
    chk("b2b_core_key_s1", bus.core_key_s1, MSK1);
    bus.core_done = 1'b0;

    // async reset on RUN cycle 20
    for (int i = 0; i < 20; i++) tick();
    chk("pre_reset_busy", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("areset_busy", 128'(bus.busy), 128'd0);
    chk("areset_core_pt", bus.core_pt_s0 | bus.core_pt_s1 | bus.core_key_s0 | bus.core_key_s1, 128'd0);
    chk("areset_out_ct", bus.out_ct_s0 | bus.out_ct_s1, 128'd0);
    chk("areset_out_valid", 128'(bus.out_valid), 128'd0);
    tick();
    rst = 1'b0;
    bus.core_done  = 1'b1;
    bus.core_ct_s0 = CT0 ^ MSK0;
    bus.core_ct_s1 = MSK0;
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen_valid = 1'b1;
    end
    chk("late_done_ignored", 128'(seen_valid), 128'd0);

`ifdef AES_SEQ_WATCHDOG_EN
    // watchdog abort after 64 RUN cycles
    drive_in(PT0, 128'd0, KEY0, 128'd0);
    tick();
    bus.in_valid  = 1'b0;
    tick();
    bus.core_done = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 63; i++) begin
      if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
      tick();
    end
    chk("wd_run64_busy", 128'(bus.busy), 128'd1);
    chk("wd_run64_err", 128'(bus.err), 128'd0);
    tick();
    chk("wd_err", 128'(bus.err), 128'd1);
    chk("wd_idle", 128'(bus.in_ready), 128'd1);
    chk("wd_busy", 128'(bus.busy), 128'd0);
    chk("wd_cleared", bus.core_pt_s0 | bus.core_key_s0 | bus.out_ct_s0 | bus.out_ct_s1, 128'd0);
    chk("wd_no_valid", 128'(seen_valid | bus.out_valid), 128'd0);
    tick();
    chk("wd_err_sticky", 128'(bus.err), 128'd1);
    // next accept clears err; done exactly on RUN cycle 64 wins over the limit
    drive_in(PT0, 128'd0, KEY0, 128'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("wd_err_clear", 128'(bus.err), 128'd0);
    tick();
    for (int i = 0; i < 63; i++) tick();
    bus.core_done  = 1'b1;
    bus.core_ct_s0 = CT0 ^ MSK0;
    bus.core_ct_s1 = MSK0;
    tick();
    chk("wd_edge_valid", 128'(bus.out_valid), 128'd1);
    chk("wd_edge_err", 128'(bus.err), 128'd0);
    chk("wd_edge_ct", bus.out_ct_s0 ^ bus.out_ct_s1, CT0);
`else
    // no watchdog: done on RUN cycle 200 still completes
    drive_in(PT0, 128'd0, KEY0, 128'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.core_done = 1'b0;
    for (int i = 0; i < 199; i++) tick();
    chk("long_busy", 128'(bus.busy), 128'd1);
    chk("long_no_valid", 128'(bus.out_valid), 128'd0);
    bus.core_done  = 1'b1;
    bus.core_ct_s0 = CT1 ^ MSK0;
    bus.core_ct_s1 = MSK0;
    tick();
    chk("long_valid", 128'(bus.out_valid), 128'd1);
    chk("long_ct", bus.out_ct_s0 ^ bus.out_ct_s1, CT1);
    chk("long_err", 128'(bus.err), 128'd0);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("final_idle", 128'(bus.in_ready), 128'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
